// File: rtl/hamming_pkg.sv
// Shared codeword geometry for the (128,120) extended Hamming encoder/decoder pair.
// Arrival index 0 is overall parity, powers of two are Hamming parity, the rest carry data.
package hamming_pkg;

  localparam int N = 128;
  localparam int K = 120;
  localparam int M = 7;

  localparam logic [M-1:0] FIRST_DATA_POS = M'(3);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } dec_state_t;

  function automatic logic is_parity_pos(input logic [M-1:0] p);
    return (p == '0) || ((p & (p - M'(1))) == '0);
  endfunction

endpackage

// File: rtl/hamming_syndrome_acc.sv
// Serial syndrome/parity accumulator: tracks the arrival index of each accepted bit and
// folds it into syn/par; the final values are exposed combinationally for the last bit.
module hamming_syndrome_acc
  import hamming_pkg::*;
#(
  parameter int N = hamming_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_bit,
  input  logic         data_vld,
  output logic [M-1:0] pos,
  output logic [M-1:0] syn_next,
  output logic         par_next,
  output logic         last
);

  localparam logic [M-1:0] LAST_POS = M'(N - 1);

  logic [M-1:0] pos_q;
  logic [M-1:0] syn_q;
  logic         par_q;

  assign pos      = pos_q;
  assign last     = data_vld && (pos_q == LAST_POS);
  assign syn_next = data_bit ? (syn_q ^ pos_q) : syn_q;
  assign par_next = par_q ^ data_bit;

  // Accumulators clear on the last bit so the next word starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      syn_q <= '0;
      par_q <= 1'b0;
    end else if (data_vld) begin
      if (last) begin
        pos_q <= '0;
        syn_q <= '0;
        par_q <= 1'b0;
      end else begin
        pos_q <= pos_q + M'(1);
        syn_q <= syn_next;
        par_q <= par_next;
      end
    end
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Bit-serial SECDED decoder: collects a 128-bit codeword, then drains its 120 data bits
// from a hold buffer with single-error correction while the next word is being received.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int N     = hamming_pkg::N,
  parameter int K     = hamming_pkg::K,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_in_valid,
  output logic             data_out,
  output logic             valid,
  output logic             err_corrected,
  output logic             err_detected,
  output logic [CNT_W-1:0] corrected_count,
  output logic [CNT_W-1:0] uncorrectable_count
);

  localparam int DC_W = $clog2(K);
  localparam logic [DC_W-1:0] LAST_DC = DC_W'(K - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // At most one parity position can follow a data position once past index 3.
  function automatic logic [M-1:0] next_data_pos(input logic [M-1:0] p);
    logic [M-1:0] n;
    n = p + M'(1);
    if (is_parity_pos(n)) n = n + M'(1);
    return n;
  endfunction

  logic [M-1:0] pos;
  logic [M-1:0] syn_next;
  logic         par_next;
  logic         last;

  hamming_syndrome_acc #(.N(N)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .data_bit (data_in),
    .data_vld (data_in_valid),
    .pos      (pos),
    .syn_next (syn_next),
    .par_next (par_next),
    .last     (last)
  );

  logic [N-1:0] word_acc;
  logic [N-1:0] hold_buf;

  always_ff @(posedge clk) begin
    if (data_in_valid) word_acc[pos] <= data_in;
    if (last) begin
      hold_buf        <= word_acc;
      hold_buf[N-1]   <= data_in;
    end
  end

  dec_state_t      state_q, state_d;
  logic            drain_en;
  logic            drain_done;
  logic [M-1:0]    rd_pos;
  logic [DC_W-1:0] dc_q;
  logic [M-1:0]    syn_h;
  logic            par_h;

  assign drain_done = drain_en && (dc_q == LAST_DC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (last) state_d = DRAIN;
      DRAIN:   if (drain_done && !last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drain_en = 1'b0;
    case (state_q)
      DRAIN:   drain_en = 1'b1;
      default: drain_en = 1'b0;
    endcase
  end

  // A transfer on the final drain edge reloads the pointer and class while the old
  // word's last bit is still read from the hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pos <= FIRST_DATA_POS;
      dc_q   <= '0;
      syn_h  <= '0;
      par_h  <= 1'b0;
    end else if (last) begin
      rd_pos <= FIRST_DATA_POS;
      dc_q   <= '0;
      syn_h  <= syn_next;
      par_h  <= par_next;
    end else if (drain_en) begin
      rd_pos <= next_data_pos(rd_pos);
      dc_q   <= dc_q + DC_W'(1);
    end
  end

  logic data_p0;
  logic vld_p0;
  logic corr_p0;
  logic det_p0;
  logic inc_c_p0;
  logic first_rd;

  assign first_rd = drain_en && (dc_q == '0);

  // Stage p0: read hold buffer and apply correction.
  always_ff @(posedge clk) begin
    data_p0 <= hold_buf[rd_pos] ^ (par_h && (rd_pos == syn_h));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      corr_p0  <= 1'b0;
      det_p0   <= 1'b0;
      inc_c_p0 <= 1'b0;
    end else begin
      vld_p0   <= drain_en;
      corr_p0  <= first_rd && par_h && (syn_h != '0);
      det_p0   <= first_rd && !par_h && (syn_h != '0);
      inc_c_p0 <= first_rd && par_h;
    end
  end

  // Stage p1: registered outputs and saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out            <= 1'b0;
      valid               <= 1'b0;
      err_corrected       <= 1'b0;
      err_detected        <= 1'b0;
      corrected_count     <= '0;
      uncorrectable_count <= '0;
    end else begin
      data_out      <= vld_p0 & data_p0;
      valid         <= vld_p0;
      err_corrected <= corr_p0;
      err_detected  <= det_p0;
      if (inc_c_p0) corrected_count     <= sat_inc(corrected_count);
      if (det_p0)   uncorrectable_count <= sat_inc(uncorrectable_count);
    end
  end

endmodule

// File: doc/hamming_secded_dec.md
HAMMING_SECDED_DEC -- requirements
Module: hamming_secded_dec

Interface
REQ-001 SHALL have parameter N, default 128, codeword length in bits.
REQ-002 SHALL have parameter K, default 120, data bits per codeword.
REQ-003 SHALL have parameter CNT_W, default 32, error-counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  input  1  received hard-decision codeword bit.
REQ-007 SHALL have port data_in_valid  input  1  data_in is accepted this cycle; there is no backpressure.
REQ-008 SHALL have port data_out  output  1  corrected data bit.
REQ-009 SHALL have port valid  output  1  data_out is valid this cycle.
REQ-010 SHALL have port err_corrected  output  1  one-cycle pulse: the current codeword had a single error, which was corrected.
REQ-011 SHALL have port err_detected  output  1  one-cycle pulse: the current codeword had an uncorrectable double error.
REQ-012 SHALL have port corrected_count  output  CNT_W  count of corrected codewords.
REQ-013 SHALL have port uncorrectable_count  output  CNT_W  count of uncorrectable codewords.

Function
REQ-014 SHALL use the codeword layout produced by hamming_enc: arrival index p = 0..127; p=0 holds overall parity; p = 1,2,4,…,64 hold Hamming parity; the remaining 120 positions hold data, in ascending p order.
REQ-015 SHALL accept one bit per cycle with data_in_valid=1; the first accepted bit after reset is p=0; p wraps from 127 to 0.
REQ-016 SHALL accumulate syndrome incrementally: syn ^= p whenever an accepted bit is 1 (7 bits); par ^= bit over all 128 bits.
REQ-017 SHALL, on the edge accepting p=127, transfer the word into a hold buffer, latch the final syn and par, and clear the accumulators for the next word (ping-pong).
REQ-018 SHALL classify: syn=0,par=0 → clean; par=1 → single error at position syn (syn=0 means the p=0 parity bit); syn≠0,par=0 → uncorrectable, with bits passed unmodified.
REQ-019 SHALL emit the 120 data bits of the hold buffer on 120 consecutive cycles (valid=1), in ascending p order, with data_out = bit XOR (single-error AND p==syn).
REQ-020 SHALL assert the first valid exactly 2 rising edges after the p=127 accept edge.
REQ-021 SHALL assert err_corrected/err_detected for exactly one cycle, coincident with the first data bit of the affected word; both SHALL be 0 for a clean word or an error at p=0 (that case is still counted as corrected).
REQ-022 SHALL increment each counter by 1 at that pulse, saturating at all-ones.
REQ-023 SHALL keep accepting input during output draining; accepting p=127 while a drain is still active cannot occur under the input rate of at most 1 bit per cycle, and the design need not handle it.
REQ-024 SHALL ignore data_in when data_in_valid=0; a gap does not alter p, syn, par or the drain.
REQ-025 SHALL have an FSM with states IDLE (no word held) and DRAIN (emitting); IDLE→DRAIN on hold transfer; DRAIN→IDLE after the 120th bit unless a new transfer occurs on that same edge, in which case it stays in DRAIN.

Reset
REQ-026 SHALL, while rst=1, force data_out=0, valid=0, err pulses=0, counters=0, p=0, syn=0, par=0 and FSM=IDLE, and discard any partial or held word.
REQ-027 SHALL treat the first valid bit after rst deasserts as p=0; a reset asserted mid-drain SHALL truncate the output immediately.

Structure
REQ-028 SHALL take N, K, the parity-bit width M=7 and an is-parity-position function from shared package hamming_pkg, which hamming_enc also uses.
REQ-029 SHALL instantiate one sub-module, hamming_syndrome_acc, holding p, syn and par, with a last-bit strobe.

Verification
REQ-030 SHALL cover: an all-zero codeword → 120 zeros, no pulses, counters 0.
REQ-031 SHALL cover: an encoder word of PRBS data with bit p=37 flipped → output equals the source data, err_corrected pulse, corrected_count=1.
REQ-032 SHALL cover: bits p=5 and p=90 flipped → err_detected, uncorrectable_count=1, output equals the raw data positions.
REQ-033 SHALL cover: a p=0 flip → clean data, no pulse, corrected_count increments.
REQ-034 SHALL cover: three back-to-back codewords with data_in_valid=1 continuously → 360 bits correct, first valid 2 edges after bit 127.
REQ-035 SHALL cover: rst asserted at p=64 of the second word, then a new clean word → no output from the partial word, clean output afterwards.
